// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Bundles the three buses around the ALU command sequencer:
//     - request port   : REQ_VALID/REQ_READY plus the operation fields
//     - ALU pin port   : OPA/OPB/CIN/MODE/CMD/IN_VALID/CE out, RES and flags in
//     - response port  : RSP_VALID/RSP_READY plus captured RES and flags
//   modport slave  : the sequencer's view (accepts requests, drives the ALU)
//   modport master : the environment's view (host, consumer and ALU model)
interface alu_cmd_sequencer_if #(
    parameter int N1    = 8,
    parameter int N2    = 4,
    parameter int RES_W = 9
);
    // request
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_MODE;
    logic [N2-1:0]    REQ_CMD;
    logic [N1-1:0]    REQ_OPA;
    logic [N1-1:0]    REQ_OPB;
    logic             REQ_CIN;
    logic [1:0]       REQ_IN_VALID;
    // ALU pins
    logic [N1-1:0]    OPA;
    logic [N1-1:0]    OPB;
    logic             CIN;
    logic             MODE;
    logic [N2-1:0]    CMD;
    logic [1:0]       IN_VALID;
    logic             CE;
    logic [RES_W-1:0] RES;
    logic             COUT;
    logic             OFLOW;
    logic             G;
    logic             E;
    logic             L;
    logic             ERR;
    // response
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [RES_W-1:0] RSP_RES;
    logic [5:0]       RSP_FLAGS;

    modport slave (
        input  REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN, REQ_IN_VALID,
        output REQ_READY,
        output OPA, OPB, CIN, MODE, CMD, IN_VALID, CE,
        input  RES, COUT, OFLOW, G, E, L, ERR,
        output RSP_VALID, RSP_RES, RSP_FLAGS,
        input  RSP_READY
    );

    modport master (
        output REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN, REQ_IN_VALID,
        input  REQ_READY,
        input  OPA, OPB, CIN, MODE, CMD, IN_VALID, CE,
        output RES, COUT, OFLOW, G, E, L, ERR,
        input  RSP_VALID, RSP_RES, RSP_FLAGS,
        output RSP_READY
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Hardware initiator for one ALU instance. Accepts one operation on the request
//   port, drives the ALU pins for the command's latency, captures RES and flags and
//   returns them on the response port. One operation in flight at a time.
// Ports
//   CLK      clock, all logic on posedge
//   RST      synchronous active-high reset
//   bus      alu_cmd_sequencer_if.slave (request, ALU pins, response)
//   ERR_CLR  leaves HALT (error-stop build only, otherwise unused)
//   HALTED   error-stop state indicator (tied 0 unless error-stop build)
// Build option
//   ALU_SEQ_ERRSTOP_EN : when defined, handing off a response with FLAGS[0]=1
//   parks the sequencer in HALT until ERR_CLR is pulsed.
// Parameters
//   N1/N2/RES_W must match the ALU; MUL_LAT (1..15) is the multiply latency.
module alu_cmd_sequencer #(
    parameter int N1      = 8,
    parameter int N2      = 4,
    parameter int RES_W   = 9,
    parameter int MUL_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST,
    alu_cmd_sequencer_if.slave  bus,
    input  logic                ERR_CLR,
    output logic                HALTED
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       lat_q, lat_d;
    logic [N1-1:0]    opa_q, opa_d;
    logic [N1-1:0]    opb_q, opb_d;
    logic             cin_q, cin_d;
    logic             mode_q, mode_d;
    logic [N2-1:0]    cmd_q, cmd_d;
    logic [1:0]       in_valid_q, in_valid_d;
    logic [RES_W-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]       rsp_flags_q, rsp_flags_d;

    logic             req_fire;
    logic             rsp_fire;
    logic             is_mul;

    assign req_fire = bus.REQ_VALID && (state_q == S_IDLE);
    assign rsp_fire = bus.RSP_READY && (state_q == S_RESP);
    assign is_mul   = bus.REQ_MODE && ((bus.REQ_CMD == N2'(9)) || (bus.REQ_CMD == N2'(10)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cin_d       = cin_q;
        mode_d      = mode_q;
        cmd_d       = cmd_q;
        in_valid_d  = in_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (bus.REQ_IN_VALID == 2'b00) begin
                        // Nothing valid to operate on: answer locally with ERR and
                        // leave the ALU pins untouched.
                        rsp_res_d   = '0;
                        rsp_flags_d = 6'b000001;
                        state_d     = S_RESP;
                    end else begin
                        opa_d      = bus.REQ_OPA;
                        opb_d      = bus.REQ_OPB;
                        cin_d      = bus.REQ_CIN;
                        mode_d     = bus.REQ_MODE;
                        cmd_d      = bus.REQ_CMD;
                        in_valid_d = bus.REQ_IN_VALID;
                        lat_d      = is_mul ? 4'(MUL_LAT) : 4'd1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = lat_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt==1 marks the last CE cycle: ALU outputs are valid at this edge.
                if (cnt_q == 4'd1) begin
                    rsp_res_d   = bus.RES;
                    rsp_flags_d = {bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR};
                    in_valid_d  = 2'b00;
                    state_d     = S_RESP;
                end
                cnt_d = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (rsp_fire) begin
`ifdef ALU_SEQ_ERRSTOP_EN
                    state_d = rsp_flags_q[0] ? S_HALT : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef ALU_SEQ_ERRSTOP_EN
            S_HALT: begin
                if (ERR_CLR) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin_q       <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            in_valid_q  <= 2'b00;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cin_q       <= cin_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            in_valid_q  <= in_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.REQ_READY = (state_q == S_IDLE);
    assign bus.CE        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.OPA       = opa_q;
    assign bus.OPB       = opb_q;
    assign bus.CIN       = cin_q;
    assign bus.MODE      = mode_q;
    assign bus.CMD       = cmd_q;
    assign bus.IN_VALID  = in_valid_q;
    assign bus.RSP_VALID = (state_q == S_RESP);
    assign bus.RSP_RES   = rsp_res_q;
    assign bus.RSP_FLAGS = rsp_flags_q;

`ifdef ALU_SEQ_ERRSTOP_EN
    assign HALTED = (state_q == S_HALT);
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign HALTED         = 1'b0;
`endif

endmodule
